// File: rtl/uart_program_dump.sv
// uart_program_dump: reads NUM_WORDS instruction words from the RAM read port
// and sends each as four 8N1 UART bytes (MSB byte first, LSB bit first).
module uart_program_dump #(
    parameter int BAUD_DIV  = 10416,
    parameter int NUM_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] RdData,
    output logic [3:0]  RdAddrs,
    output logic        TxD,
    output logic        busy,
    output logic        done
);

    localparam int             BW        = $clog2(BAUD_DIV);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0]  BAUD_ZERO = {BW{1'b0}};
    localparam logic [BW-1:0]  BAUD_ONE  = BW'(1);
    localparam logic [3:0]     LAST_ADDR = 4'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [BW-1:0]  r_baud, w_baud_nxt;
    logic [2:0]     r_bit, w_bit_nxt;
    logic [1:0]     r_byte, w_byte_nxt;
    logic [31:0]    r_word, w_word_nxt;
    logic [3:0]     r_addr, w_addr_nxt;
    logic           r_txd, w_txd_nxt;
    logic           r_busy, w_busy_nxt;
    logic           r_done, w_done_nxt;

    logic           w_tick;
    logic [2:0]     w_bit_inc;
    logic [7:0]     w_cur_byte;

    assign w_tick    = (r_baud == BAUD_LAST);
    assign w_bit_inc = r_bit + 3'd1;

    // Select the byte currently on the line, most significant byte first
    always_comb begin
        case (r_byte)
            2'd0:    w_cur_byte = r_word[31:24];
            2'd1:    w_cur_byte = r_word[23:16];
            2'd2:    w_cur_byte = r_word[15:8];
            2'd3:    w_cur_byte = r_word[7:0];
            default: w_cur_byte = 8'h00;
        endcase
    end

    // Next-state and next-output logic; TxD is computed one cycle ahead so the pin is a flop
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_word_nxt  = r_word;
        w_addr_nxt  = r_addr;
        w_txd_nxt   = r_txd;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_txd_nxt = 1'b1;
                if (start) begin
                    w_state_nxt = S_FETCH;
                    w_busy_nxt  = 1'b1;
                    w_addr_nxt  = 4'd0;
                    w_byte_nxt  = 2'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            // one cycle of address hold covers registered-output RAMs
            S_FETCH: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_word_nxt  = RdData;
                w_baud_nxt  = BAUD_ZERO;
                w_txd_nxt   = 1'b0;
                w_state_nxt = S_START;
            end
            S_START: begin
                if (w_tick) begin
                    w_baud_nxt  = BAUD_ZERO;
                    w_bit_nxt   = 3'd0;
                    w_txd_nxt   = w_cur_byte[0];
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_baud_nxt = BAUD_ZERO;
                    if (r_bit == 3'd7) begin
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = w_bit_inc;
                        w_txd_nxt = w_cur_byte[w_bit_inc];
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_ONE;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_baud_nxt = BAUD_ZERO;
                    if (r_byte != 2'd3) begin
                        // next byte of the same word follows back-to-back
                        w_byte_nxt  = r_byte + 2'd1;
                        w_txd_nxt   = 1'b0;
                        w_state_nxt = S_START;
                    end else if (r_addr != LAST_ADDR) begin
                        w_addr_nxt  = r_addr + 4'd1;
                        w_byte_nxt  = 2'd0;
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_addr_nxt  = 4'd0;
                        w_byte_nxt  = 2'd0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_txd_nxt   = 1'b1;
                w_busy_nxt  = 1'b0;
                w_addr_nxt  = 4'd0;
            end
        endcase
    end

    // State, counter and output registers; reset abandons any frame and idles the line high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= BAUD_ZERO;
            r_bit   <= 3'd0;
            r_byte  <= 2'd0;
            r_word  <= 32'h0000_0000;
            r_addr  <= 4'd0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_byte  <= w_byte_nxt;
            r_word  <= w_word_nxt;
            r_addr  <= w_addr_nxt;
            r_txd   <= w_txd_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign RdAddrs = r_addr;
    assign TxD     = r_txd;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_uart_program_dump.sv
// Scoreboard bench: two DUT instances (BAUD_DIV=4/NUM_WORDS=2 and BAUD_DIV=2/NUM_WORDS=16).
// Stimulus pushes expected bytes/timing; a UART decoder monitor pops and compares.
module tb_uart_program_dump;

    localparam int BD_A = 4;
    localparam int NW_A = 2;
    localparam int BD_B = 2;
    localparam int NW_B = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic [3:0]  addr_a, addr_b;
    logic        txd_a, txd_b, busy_a, busy_b, done_a, done_b;
    logic [31:0] ram_a [NW_A];
    logic [31:0] ram_b [NW_B];
    logic [31:0] rd_a, rd_b;

    assign rd_a = ram_a[addr_a[0]];
    assign rd_b = ram_b[addr_b];

    uart_program_dump #(.BAUD_DIV(BD_A), .NUM_WORDS(NW_A)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .RdData(rd_a),
        .RdAddrs(addr_a), .TxD(txd_a), .busy(busy_a), .done(done_a)
    );

    uart_program_dump #(.BAUD_DIV(BD_B), .NUM_WORDS(NW_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .RdData(rd_b),
        .RdAddrs(addr_b), .TxD(txd_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         inst;
        logic [7:0] data;
        int         offset;
        int         addr;
    } frame_t;
    typedef struct {
        int inst;
        int offset;
    } done_t;

    frame_t      sbq[$];
    done_t       dq[$];
    int          base = 0;
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] words_g [16];

    function automatic int bd(input int i);
        return (i == 0) ? BD_A : BD_B;
    endfunction

    function automatic int nw(input int i);
        return (i == 0) ? NW_A : NW_B;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- monitor: UART decoder + done checker ----------------
    bit         in_frame [2];
    bit         fr_ok    [2];
    int         fr_n     [2];
    int         fr_fall  [2];
    logic [3:0] fr_addr  [2];
    logic [7:0] fr_rx    [2];
    logic       m_txd, m_done, m_busy;
    logic [3:0] m_addr;
    int         m_b, m_idx, m_ph;
    frame_t     m_f;
    done_t      m_d;

    initial begin
        for (int i = 0; i < 2; i++) in_frame[i] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                m_b    = bd(i);
                m_txd  = (i == 0) ? txd_a  : txd_b;
                m_done = (i == 0) ? done_a : done_b;
                m_busy = (i == 0) ? busy_a : busy_b;
                m_addr = (i == 0) ? addr_a : addr_b;
                if (rst) begin
                    in_frame[i] = 1'b0;
                end else begin
                    if (m_done === 1'b1) begin
                        chk("done_expected", 32'(dq.size() != 0), 32'd1);
                        if (dq.size() != 0) begin
                            m_d = dq.pop_front();
                            chk("done_inst", 32'(i), 32'(m_d.inst));
                            chk("done_time", 32'(cyc - base), 32'(m_d.offset));
                            chk("done_busy", 32'(m_busy), 32'd0);
                            chk("done_addr", 32'(m_addr), 32'd0);
                        end
                    end
                    if (!in_frame[i]) begin
                        if (m_txd === 1'b0) begin
                            in_frame[i] = 1'b1;
                            fr_n[i]     = 1;
                            fr_ok[i]    = 1'b1;
                            fr_fall[i]  = cyc;
                            fr_addr[i]  = m_addr;
                        end
                    end else begin
                        m_idx = fr_n[i] / m_b;
                        m_ph  = fr_n[i] % m_b;
                        if (m_idx == 0) begin
                            if (m_txd !== 1'b0) fr_ok[i] = 1'b0;
                        end else if (m_idx <= 8) begin
                            if (m_ph == 0) fr_rx[i][m_idx-1] = m_txd;
                            else if (m_txd !== fr_rx[i][m_idx-1]) fr_ok[i] = 1'b0;
                        end else begin
                            if (m_txd !== 1'b1) fr_ok[i] = 1'b0;
                        end
                        fr_n[i]++;
                        if (fr_n[i] == 10 * m_b) begin
                            in_frame[i] = 1'b0;
                            chk("frame_expected", 32'(sbq.size() != 0), 32'd1);
                            if (sbq.size() != 0) begin
                                m_f = sbq.pop_front();
                                chk("frame_inst",  32'(i), 32'(m_f.inst));
                                chk("frame_shape", 32'(fr_ok[i]), 32'd1);
                                chk("frame_data",  32'(fr_rx[i]), 32'(m_f.data));
                                chk("frame_time",  32'(fr_fall[i] - base), 32'(m_f.offset));
                                chk("frame_addr",  32'(fr_addr[i]), 32'(m_f.addr));
                            end
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus + reference model ----------------
    task automatic run_dump(input int inst, input int restart_at, input int reset_at, input bit scramble);
        int          n, b, limit;
        logic [31:0] w;
        frame_t      f;
        done_t       d;
        n = nw(inst);
        b = bd(inst);
        for (int i = 0; i < n; i++) begin
            if (inst == 0) ram_a[i] = words_g[i];
            else           ram_b[i] = words_g[i];
        end
        // Expected stream: byte k of the dump, MSB byte of each word first,
        // each frame 10 bit times, 2 extra high cycles before every later word.
        for (int k = 0; k < 4 * n; k++) begin
            w        = words_g[k / 4];
            f.inst   = inst;
            f.data   = 8'(w >> (8 * (3 - (k % 4))));
            f.offset = 2 + k * 10 * b + (k / 4) * 2;
            f.addr   = k / 4;
            sbq.push_back(f);
        end
        d.inst   = inst;
        d.offset = 2 + n * 40 * b + (n - 1) * 2;
        dq.push_back(d);

        @(negedge clk);
        if (inst == 0) start_a = 1'b1;
        else           start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        base = cyc;
        chk("busy_on_start", 32'((inst == 0) ? busy_a : busy_b), 32'd1);
        chk("addr_on_start", 32'((inst == 0) ? addr_a : addr_b), 32'd0);

        limit = 2 + n * 40 * b + n * 2 + 20;
        for (int c = 0; c < limit; c++) begin
            if (sbq.size() == 0 && dq.size() == 0) break;
            if (scramble && cyc == base + 5) begin
                if (inst == 0) ram_a[0] = $urandom;
                else           ram_b[0] = $urandom;
            end
            if (restart_at != 0 && cyc == base + restart_at) begin
                if (inst == 0) start_a = 1'b1;
                else           start_b = 1'b1;
            end else begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            if (reset_at != 0 && cyc == base + reset_at) begin
                #1 rst = 1'b1;
                #1;
                chk("midrst_txd",  32'(txd_a),  32'd1);
                chk("midrst_busy", 32'(busy_a), 32'd0);
                chk("midrst_done", 32'(done_a), 32'd0);
                chk("midrst_addr", 32'(addr_a), 32'd0);
                sbq.delete();
                dq.delete();
                repeat (2) @(negedge clk);
                rst = 1'b0;
                break;
            end
            @(negedge clk);
        end
        start_a = 1'b0;
        start_b = 1'b0;
        chk("dump_drained", 32'(sbq.size() + dq.size()), 32'd0);
        repeat (10) @(negedge clk);
    endtask

    bit idle_ok;

    initial begin
        for (int i = 0; i < NW_A; i++) ram_a[i] = 32'h0;
        for (int i = 0; i < NW_B; i++) ram_b[i] = 32'h0;

        // Reset and idle behaviour
        #1 rst = 1'b1;
        #2;
        chk("rst_a", 32'({txd_a, busy_a, done_a, addr_a}), 32'h40);
        chk("rst_b", 32'({txd_b, busy_b, done_b, addr_b}), 32'h40);
        @(negedge clk);
        rst = 1'b0;
        idle_ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if ({txd_a, busy_a, done_a, addr_a} !== 7'h40) idle_ok = 1'b0;
            if ({txd_b, busy_b, done_b, addr_b} !== 7'h40) idle_ok = 1'b0;
        end
        chk("idle_hold", 32'(idle_ok), 32'd1);

        // Two words, boundary patterns
        words_g[0] = 32'h0000_0001;
        words_g[1] = 32'hFFFF_FFFE;
        run_dump(0, 0, 0, 1'b0);

        // RAM word 0 changes after it was loaded: stream must not change
        words_g[0] = 32'hA5C3_0F81;
        words_g[1] = $urandom;
        run_dump(0, 0, 0, 1'b1);

        // Start pulsed again mid-dump is ignored
        words_g[0] = $urandom;
        words_g[1] = $urandom;
        run_dump(0, 60, 0, 1'b0);

        // Reset during data bit 3 of byte 1 (that bit is 0 here), then a clean dump
        words_g[0] = 32'h1200_3456;
        words_g[1] = $urandom;
        run_dump(0, 0, 2 + 14 * BD_A + 1, 1'b0);
        words_g[0] = $urandom;
        words_g[1] = $urandom;
        run_dump(0, 0, 0, 1'b0);

        // Full 16-word dump
        for (int i = 0; i < 16; i++) words_g[i] = 32'(i) * 32'h0101_0101;
        run_dump(1, 0, 0, 1'b0);
        for (int i = 0; i < 16; i++) words_g[i] = $urandom;
        run_dump(1, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_program_dump.md
# uart_program_dump

Serial program read-back transmitter for the microcontroller. On a start pulse it reads the instruction RAM word by word through the RAM read port and sends each 32-bit word out on `TxD` as four 8N1 UART bytes. It is the transmit-side counterpart of the RxD program loader, so a host can verify what was written.

## Interface
- `BAUD_DIV`, 10416: clock cycles per UART bit; 9600 baud at 100 MHz; must be ≥ 2.
- `NUM_WORDS`, 16: number of words dumped, from address 0 to NUM_WORDS-1; range 1..16.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to begin a dump; sampled only in IDLE.
- `RdData`  in  32  instruction word from the RAM read port.
- `RdAddrs`  out  4  RAM read address.
- `TxD`  out  1  UART serial output; idles high.
- `busy`  out  1  high while a dump is in progress.
- `done`  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- Reset values: `TxD`=1, `busy`=0, `done`=0, `RdAddrs`=0, state IDLE. All counters are cleared.
- States: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE:
  - `start`=1 → FETCH, `busy`←1, `RdAddrs`←0, byte index←0.
- FETCH:
  - Holds `RdAddrs` for one cycle so that both combinational and one-cycle-registered RAM reads are valid.
  - → LOAD.
- LOAD:
  - Captures `RdData` into a 32-bit shift word.
  - → START.
- Byte order: MSB byte first (bits 31:24, 23:16, 15:8, 7:0). Within each byte, LSB first.
- START: `TxD`=0 for BAUD_DIV cycles → DATA.
- DATA:
  - 8 bits, each held for BAUD_DIV cycles.
  - → STOP after bit 7.
- STOP: `TxD`=1 for BAUD_DIV cycles. At the end of STOP:
  - byte index < 3 → index+1, → START directly, with no extra idle cycles.
  - byte index = 3 and `RdAddrs` < NUM_WORDS-1 → `RdAddrs`+1, index←0, → FETCH.
  - byte index = 3 and `RdAddrs` = NUM_WORDS-1 → IDLE, `busy`←0, `done`←1 for exactly one cycle, `RdAddrs`←0.
- `TxD` is driven from a register, so it never glitches.
- `start` is ignored while `busy`=1; it does not queue.
- `start` held high in IDLE across the `done` cycle starts a new dump on the first IDLE cycle. This is allowed.
- `RdData` is sampled only in LOAD. Changes to `RdData` at any other time have no effect on the byte in flight.
- Reset mid-operation:
  - `TxD` returns to 1 immediately (asynchronous).
  - A partial frame is abandoned.
  - No `done` pulse is generated.

## Timing
- `start` sampled at edge N:
  - `busy`=1 and `RdAddrs`=0 from edge N.
  - FETCH for cycle N, LOAD for cycle N+1.
  - `TxD` falls at edge N+2.
- Per byte: exactly 10·BAUD_DIV cycles (start, 8 data, stop).
- Per word: 40·BAUD_DIV cycles of frames, plus 2 high cycles (FETCH, LOAD) before every word after the first.
- Total dump, from the `TxD` fall of word 0 to `done`: NUM_WORDS·40·BAUD_DIV + (NUM_WORDS-1)·2 cycles.
- `done` and `busy` falling occur on the same edge, the one ending the last stop bit.
- Bit-period counter: counts 0..BAUD_DIV-1. The bit advances on the terminal count, with no off-by-one (each level is held for exactly BAUD_DIV cycles).

## Test plan
- Reset/idle: assert `rst` asynchronously → `TxD`=1, `busy`=0, `done`=0, `RdAddrs`=0. Release `rst`, with no `start` for 100 cycles → outputs unchanged.
- Single word (BAUD_DIV=4, NUM_WORDS=1):
  - RAM[0]=0xA5C3_0F81, then pulse `start` → serial bytes decode as 0xA5, 0xC3, 0x0F, 0x81.
  - Each bit lasts 4 cycles; `TxD` falls 2 cycles after `start`.
  - `done` pulses once, 160 cycles after the first fall.
- Two words (BAUD_DIV=4, NUM_WORDS=2):
  - RAM[0]=0x0000_0001, RAM[1]=0xFFFF_FFFE → 8 bytes: 00 00 00 01 FF FF FF FE.
  - `RdAddrs` steps 0→1 at the end of byte 3.
  - TxD is high for exactly 2 cycles between the stop bit of byte 3 and the next start bit.
  - `done` at 322 cycles after the first fall.
- Start while busy: pulse `start` again mid-dump → no restart, byte stream identical to the single-start case, one `done` only.
- Reset mid-frame: assert `rst` during DATA bit 3 of byte 1 → `TxD`=1 in the same cycle, `busy`=0, no `done`. A new `start` then produces a clean dump from address 0.
- Full dump (BAUD_DIV=2, NUM_WORDS=16):
  - RAM[i]=i·0x0101_0101 → 64 bytes decode correctly.
  - `RdAddrs` wraps to 0 with `done`.
  - Total length 16·80+30 = 1310 cycles.
